cordic_job_arbiter: RTL

- Shares one CORDIC core between N_REQ requesters (e.g. AXI4-Lite register front-end, DMA engine, CPU-side accelerator port).
- Arbitrates round-robin, latches the winner's angle and mode, pulses the core's start, waits for done, and returns the result to the winner.
- Guards against a hung core with a timeout, a core reset and an error response.
- Sits between the requesters and the CORDIC core's theta_deg/mode/start/rst/done/result_out pins.

---
 rtl/cordic_job_arbiter_pkg.sv | 19 +
 rtl/cordic_job_arbiter_rr_arbiter.sv | 30 +++
 rtl/cordic_job_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cordic_job_arbiter_pkg.sv
// Shared types and constants for the CORDIC job arbiter: FSM states, response
// error codes and default timing parameters.
package cordic_job_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StRecover,
    StResp
  } state_e;

  localparam logic RspErrNone    = 1'b0;
  localparam logic RspErrTimeout = 1'b1;

  localparam int unsigned DefTimeout   = 64;
  localparam int unsigned DefRstCycles = 2;

endpackage

// File: rtl/cordic_job_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (wrapping) and
// returns the first asserted request as a one-hot grant plus its index.
module cordic_job_arbiter_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  always_comb begin
    int unsigned cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!grant_any && req[cand[ID_W-1:0]]) begin
        grant_any                = 1'b1;
        grant[cand[ID_W-1:0]]    = 1'b1;
        grant_idx                = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cordic_job_arbiter.sv
// Shares one CORDIC core between N_REQ requesters: round-robin accept, start
// pulse, wait for done with timeout/core-reset recovery, then respond to the winner.
module cordic_job_arbiter
  import cordic_job_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = DefTimeout,
  parameter int unsigned RST_CYCLES = DefRstCycles,
  parameter int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_theta,
  input  logic [N_REQ-1:0]        req_mode,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic [DATA_W-1:0]       cordic_theta,
  output logic                    cordic_mode,
  output logic                    cordic_start,
  output logic                    cordic_rst,
  input  logic                    cordic_done,
  input  logic [DATA_W-1:0]       cordic_result,
  output logic                    busy,
  output logic [7:0]              timeout_cnt
);

  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;
  localparam int unsigned RstW   = $clog2(RST_CYCLES) + 1;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   theta_q, theta_d;
  logic                mode_q, mode_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic                core_rst_q;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;

  cordic_job_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    theta_d    = theta_q;
    mode_d     = mode_q;
    timer_d    = timer_q;
    rst_cnt_d  = rst_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    tcnt_d     = tcnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          id_d     = grant_idx;
          rr_ptr_d = grant_idx;
          theta_d  = req_theta[32'(grant_idx) * DATA_W +: DATA_W];
          mode_d   = req_mode[grant_idx];
          state_d  = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        // done has priority over a timeout expiring in the same cycle
        if (cordic_done) begin
          rsp_data_d = cordic_result;
          rsp_err_d  = RspErrNone;
          state_d    = StResp;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = RspErrTimeout;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          rst_cnt_d  = '0;
          state_d    = StRecover;
        end
      end
      StRecover: begin
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) state_d = StResp;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      StResp: begin
        if (rsp_ready[id_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      theta_q    <= '0;
      mode_q     <= 1'b0;
      timer_q    <= '0;
      rst_cnt_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tcnt_q     <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      theta_q    <= theta_d;
      mode_q     <= mode_d;
      timer_q    <= timer_d;
      rst_cnt_q  <= rst_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tcnt_q     <= tcnt_d;
      core_rst_q <= 1'b0;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) rsp_valid[id_q] = 1'b1;
  end

  // Ready is gated by areset so nothing looks accepted while reset is held.
  assign req_ready    = (state_q == StIdle && !areset) ? grant : '0;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign cordic_theta = theta_q;
  assign cordic_mode  = mode_q;
  assign cordic_start = (state_q == StIssue);
  assign cordic_rst   = core_rst_q | (state_q == StRecover);
  assign busy         = (state_q != StIdle);
  assign timeout_cnt  = tcnt_q;

endmodule
